// File: rtl/cursor_sync_cdc_if.sv
// Mouse-sample bundle into the pixel domain plus the applied cursor state back out.
// master: mouse controller / timing side (drives samples, toggle, vblank).
// slave : cursor_sync_cdc (drives applied position, buttons and event pulses).
interface cursor_sync_cdc_if #(
   parameter int W     = 12,
   parameter int N_BTN = 2
);
   logic [W-1:0]     xpos_in;
   logic [W-1:0]     ypos_in;
   logic [N_BTN-1:0] btn_in;
   logic             upd_tgl;
   logic             vblnk_in;
   logic [W-1:0]     xpos_out;
   logic [W-1:0]     ypos_out;
   logic [N_BTN-1:0] btn_out;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic             upd_pulse;
   logic             overrun;

   modport master (
      output xpos_in, ypos_in, btn_in, upd_tgl, vblnk_in,
      input  xpos_out, ypos_out, btn_out, btn_press, btn_release, upd_pulse, overrun
   );

   modport slave (
      input  xpos_in, ypos_in, btn_in, upd_tgl, vblnk_in,
      output xpos_out, ypos_out, btn_out, btn_press, btn_release, upd_pulse, overrun
   );
endinterface

// File: rtl/cursor_sync_cdc.sv
// Purpose: move a mouse sample (x, y, buttons) into pclk with a toggle-qualified
//          bundled-data handshake, clamp it to the visible area, optionally defer
//          the update to vblank start, and emit button press/release pulses.
// Latency: capture SYNC_STAGES pclk after the toggle is first sampled; apply one
//          edge later (FRAME_ALIGN=0) or on the edge that sees vblnk_in rise.
// Backpressure: none; a newer sample overwrites an unapplied one and pulses overrun.
// Ports: pclk, rst (sync, active-high); bus (slave modport of cursor_sync_cdc_if):
//        inputs xpos_in/ypos_in/btn_in/upd_tgl/vblnk_in, outputs xpos_out/ypos_out/
//        btn_out/btn_press/btn_release/upd_pulse/overrun.
module cursor_sync_cdc #(
   parameter int W           = 12,
   parameter int N_BTN       = 2,
   parameter int SYNC_STAGES = 2,
   parameter int H_MAX       = 799,
   parameter int V_MAX       = 599,
   parameter int FRAME_ALIGN = 1
) (
   input logic              pclk,
   input logic              rst,
   cursor_sync_cdc_if.slave bus
);
   localparam logic [W-1:0] X_LIM = W'(H_MAX);
   localparam logic [W-1:0] Y_LIM = W'(V_MAX);

   typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   tgl_prev;
   logic                   vblnk_prev;
   logic                   new_edge;
   logic                   apply_cond;
   logic                   do_capture;
   logic                   do_apply;
   logic                   do_overrun;
   logic [W-1:0]           x_clamp;
   logic [W-1:0]           y_clamp;
   logic [W-1:0]           pend_x;
   logic [W-1:0]           pend_y;
   logic [N_BTN-1:0]       pend_btn;

   // Only the toggle crosses domains through flops; the data bus is sampled
   // directly once the toggle edge arrives, relying on the source holding it stable.
   always_ff @(posedge pclk) begin
      if (rst) begin
         sync_q   <= '0;
         tgl_prev <= 1'b0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.upd_tgl};
         tgl_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign new_edge = sync_q[SYNC_STAGES-1] ^ tgl_prev;

   // vblnk_prev resets high so a vblank already asserted out of reset is not an edge.
   always_ff @(posedge pclk) begin
      if (rst) vblnk_prev <= 1'b1;
      else     vblnk_prev <= bus.vblnk_in;
   end

   assign apply_cond = (FRAME_ALIGN != 0) ? (bus.vblnk_in & ~vblnk_prev) : 1'b1;

   assign x_clamp = (bus.xpos_in > X_LIM) ? X_LIM : bus.xpos_in;
   assign y_clamp = (bus.ypos_in > Y_LIM) ? Y_LIM : bus.ypos_in;

   // FSM: state register
   always_ff @(posedge pclk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // FSM: next state. A sample arriving on the apply edge keeps us in PEND.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (new_edge) state_nxt = PEND;
         PEND: if (apply_cond && !new_edge) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // FSM: control outputs
   always_comb begin
      do_capture = new_edge;
      do_apply   = 1'b0;
      do_overrun = 1'b0;
      if (state == PEND) begin
         do_apply   = apply_cond;
         do_overrun = ~apply_cond & new_edge;
      end
   end

   // Pending sample. On a coincident apply+capture the outputs take the old
   // pending value (read below in the same edge) before it is replaced here.
   always_ff @(posedge pclk) begin
      if (rst) begin
         pend_x   <= '0;
         pend_y   <= '0;
         pend_btn <= '0;
      end else if (do_capture) begin
         pend_x   <= x_clamp;
         pend_y   <= y_clamp;
         pend_btn <= bus.btn_in;
      end
   end

   // Applied state and single-cycle event pulses.
   always_ff @(posedge pclk) begin
      if (rst) begin
         bus.xpos_out    <= '0;
         bus.ypos_out    <= '0;
         bus.btn_out     <= '0;
         bus.btn_press   <= '0;
         bus.btn_release <= '0;
         bus.upd_pulse   <= 1'b0;
         bus.overrun     <= 1'b0;
      end else begin
         bus.upd_pulse   <= do_apply;
         bus.overrun     <= do_overrun;
         bus.btn_press   <= '0;
         bus.btn_release <= '0;
         if (do_apply) begin
            bus.xpos_out    <= pend_x;
            bus.ypos_out    <= pend_y;
            bus.btn_out     <= pend_btn;
            bus.btn_press   <= pend_btn & ~bus.btn_out;
            bus.btn_release <= ~pend_btn & bus.btn_out;
         end
      end
   end
endmodule

// File: tb/tb_cursor_sync_cdc.sv
// Bench for cursor_sync_cdc: one instance with FRAME_ALIGN=0 (u_dut0) and one with
// FRAME_ALIGN=1 (u_dut1) share the same stimulus. A sample-level reference model
// predicts every output each cycle; directed scenarios add fixed expected values.
module tb_cursor_sync_cdc;
   localparam int S = 2;

   logic        pclk = 1'b0;
   logic        rst;
   logic [11:0] x_drv, y_drv;
   logic [1:0]  b_drv;
   logic        tgl_drv, vblnk_drv;

   int n_chk = 0;
   int n_fail = 0;

   cursor_sync_cdc_if #(.W(12), .N_BTN(2)) if0 ();
   cursor_sync_cdc_if #(.W(12), .N_BTN(2)) if1 ();

   assign if0.xpos_in = x_drv;   assign if1.xpos_in = x_drv;
   assign if0.ypos_in = y_drv;   assign if1.ypos_in = y_drv;
   assign if0.btn_in = b_drv;    assign if1.btn_in = b_drv;
   assign if0.upd_tgl = tgl_drv; assign if1.upd_tgl = tgl_drv;
   assign if0.vblnk_in = vblnk_drv; assign if1.vblnk_in = vblnk_drv;

   cursor_sync_cdc #(.W(12), .N_BTN(2), .SYNC_STAGES(S), .H_MAX(799), .V_MAX(599),
                     .FRAME_ALIGN(0)) u_dut0 (.pclk(pclk), .rst(rst), .bus(if0.slave));
   cursor_sync_cdc #(.W(12), .N_BTN(2), .SYNC_STAGES(S), .H_MAX(799), .V_MAX(599),
                     .FRAME_ALIGN(1)) u_dut1 (.pclk(pclk), .rst(rst), .bus(if1.slave));

   always #5 pclk = ~pclk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model (index 0: immediate, 1: frame-aligned) ----------
   // tq holds the toggle level seen at the last S+1 clock edges; a sample is
   // recognised S edges after its toggle was first seen.
   bit          tq[$];
   bit          vprev;
   bit          live = 1'b0;
   logic [11:0] mx[2], my[2], px[2], py[2];
   logic [1:0]  mb[2], pb[2], mpr[2], mrl[2];
   logic        mup[2], mov[2], mpv[2];

   always @(posedge pclk) begin
      bit ne, ac;
      logic [11:0] cx, cy;
      if (rst) begin
         live = 1'b1;
         tq = {};
         for (int i = 0; i < S + 1; i++) tq.push_back(1'b0);
         vprev = 1'b1;
         for (int d = 0; d < 2; d++) begin
            mx[d] = '0; my[d] = '0; mb[d] = '0; px[d] = '0; py[d] = '0; pb[d] = '0;
            mpr[d] = '0; mrl[d] = '0; mup[d] = 1'b0; mov[d] = 1'b0; mpv[d] = 1'b0;
         end
      end else begin
         ne = (tq[0] != tq[1]);
         tq.push_back(tgl_drv);
         void'(tq.pop_front());
         cx = (x_drv > 12'd799) ? 12'd799 : x_drv;
         cy = (y_drv > 12'd599) ? 12'd599 : y_drv;
         for (int d = 0; d < 2; d++) begin
            ac = (d == 0) ? 1'b1 : (vblnk_drv && !vprev);
            mpr[d] = '0; mrl[d] = '0; mup[d] = 1'b0; mov[d] = 1'b0;
            if (mpv[d] && ac) begin
               mpr[d] = pb[d] & ~mb[d];
               mrl[d] = ~pb[d] & mb[d];
               mx[d] = px[d]; my[d] = py[d]; mb[d] = pb[d]; mup[d] = 1'b1;
               mpv[d] = 1'b0;
            end else if (mpv[d] && ne) begin
               mov[d] = 1'b1;
            end
            if (ne) begin
               px[d] = cx; py[d] = cy; pb[d] = b_drv; mpv[d] = 1'b1;
            end
         end
         vprev = vblnk_drv;
      end
   end

   int ovr_cnt1 = 0;
   always @(negedge pclk) begin
      if (live) begin
         check("x0", 32'(if0.xpos_out), 32'(mx[0]));
         check("y0", 32'(if0.ypos_out), 32'(my[0]));
         check("btn0", 32'(if0.btn_out), 32'(mb[0]));
         check("press0", 32'(if0.btn_press), 32'(mpr[0]));
         check("rel0", 32'(if0.btn_release), 32'(mrl[0]));
         check("upd0", 32'(if0.upd_pulse), 32'(mup[0]));
         check("ovr0", 32'(if0.overrun), 32'(mov[0]));
         check("x1", 32'(if1.xpos_out), 32'(mx[1]));
         check("y1", 32'(if1.ypos_out), 32'(my[1]));
         check("btn1", 32'(if1.btn_out), 32'(mb[1]));
         check("press1", 32'(if1.btn_press), 32'(mpr[1]));
         check("rel1", 32'(if1.btn_release), 32'(mrl[1]));
         check("upd1", 32'(if1.upd_pulse), 32'(mup[1]));
         check("ovr1", 32'(if1.overrun), 32'(mov[1]));
         if (if1.overrun === 1'b1) ovr_cnt1++;
      end
   end

   // Present a new sample; called at a negedge, the next posedge samples the toggle.
   task automatic send(input logic [11:0] x, input logic [11:0] y, input logic [1:0] b);
      x_drv = x; y_drv = y; b_drv = b; tgl_drv = ~tgl_drv;
   endtask

   int ovr_base, vcnt, hold;

   initial begin
      rst = 1'b1; x_drv = '0; y_drv = '0; b_drv = '0; tgl_drv = 1'b0; vblnk_drv = 1'b0;

      // 1: reset, then vblank toggling with no samples
      repeat (3) @(negedge pclk);
      rst = 1'b0;
      repeat (20) begin @(negedge pclk); vblnk_drv = ~vblnk_drv; end
      @(negedge pclk);
      vblnk_drv = 1'b0;
      check("rst_x0", 32'(if0.xpos_out), 0);
      check("rst_x1", 32'(if1.xpos_out), 0);
      check("rst_upd1", 32'(if1.upd_pulse), 0);

      // 2: immediate path latency, press pulse for one cycle
      send(12'd100, 12'd200, 2'b01);
      repeat (3) @(negedge pclk);
      check("t2_early_upd", 32'(if0.upd_pulse), 0);
      @(negedge pclk);
      check("t2_x", 32'(if0.xpos_out), 100);
      check("t2_y", 32'(if0.ypos_out), 200);
      check("t2_upd", 32'(if0.upd_pulse), 1);
      check("t2_press", 32'(if0.btn_press), 1);
      @(negedge pclk);
      check("t2_upd_off", 32'(if0.upd_pulse), 0);
      check("t2_press_off", 32'(if0.btn_press), 0);

      // 3: clamping
      send(12'd4095, 12'd700, 2'b01);
      repeat (5) @(negedge pclk);
      check("t3_xclamp", 32'(if0.xpos_out), 799);
      check("t3_yclamp", 32'(if0.ypos_out), 599);
      send(12'd799, 12'd0, 2'b01);
      repeat (5) @(negedge pclk);
      check("t3_x799", 32'(if0.xpos_out), 799);
      send(12'd0, 12'd599, 2'b01);
      repeat (5) @(negedge pclk);
      check("t3_x0", 32'(if0.xpos_out), 0);
      check("t3_y599", 32'(if0.ypos_out), 599);

      // 4: frame-aligned apply; flush what is pending first
      vblnk_drv = 1'b1;
      repeat (2) @(negedge pclk);
      vblnk_drv = 1'b0;
      @(negedge pclk);
      send(12'd50, 12'd60, 2'b00);
      repeat (8) @(negedge pclk);
      check("t4_hold_x", 32'(if1.xpos_out), 0);
      check("t4_hold_y", 32'(if1.ypos_out), 599);
      vblnk_drv = 1'b1;
      @(negedge pclk);
      check("t4_x", 32'(if1.xpos_out), 50);
      check("t4_upd", 32'(if1.upd_pulse), 1);
      @(negedge pclk);
      check("t4_upd_off", 32'(if1.upd_pulse), 0);
      vblnk_drv = 1'b0;
      repeat (2) @(negedge pclk);

      // 5: overrun, then toggle coincident with the vblank edge
      ovr_base = ovr_cnt1;
      send(12'd10, 12'd1, 2'b00);
      repeat (4) @(negedge pclk);
      send(12'd20, 12'd2, 2'b00);
      repeat (6) @(negedge pclk);
      check("t5_ovr_cnt", 32'(ovr_cnt1 - ovr_base), 1);
      check("t5_hold_x", 32'(if1.xpos_out), 50);
      vblnk_drv = 1'b1;
      @(negedge pclk);
      check("t5_x", 32'(if1.xpos_out), 20);
      vblnk_drv = 1'b0;
      repeat (2) @(negedge pclk);
      send(12'd30, 12'd3, 2'b00);
      repeat (4) @(negedge pclk);
      ovr_base = ovr_cnt1;
      send(12'd40, 12'd4, 2'b00);
      repeat (2) @(negedge pclk);
      vblnk_drv = 1'b1;
      @(negedge pclk);
      check("t5c_x_old", 32'(if1.xpos_out), 30);
      check("t5c_upd", 32'(if1.upd_pulse), 1);
      check("t5c_no_ovr", 32'(ovr_cnt1 - ovr_base), 0);
      repeat (3) @(negedge pclk);
      vblnk_drv = 1'b0;
      repeat (2) @(negedge pclk);
      vblnk_drv = 1'b1;
      @(negedge pclk);
      check("t5c_x_new", 32'(if1.xpos_out), 40);
      vblnk_drv = 1'b0;
      repeat (2) @(negedge pclk);

      // 6: release pulse, then reset while a sample is pending
      send(12'd1, 12'd1, 2'b11);
      repeat (5) @(negedge pclk);
      send(12'd2, 12'd2, 2'b10);
      repeat (4) @(negedge pclk);
      check("t6_rel", 32'(if0.btn_release), 1);
      check("t6_press", 32'(if0.btn_press), 0);
      @(negedge pclk);
      check("t6_rel_off", 32'(if0.btn_release), 0);
      // leave the toggle low across reset so no resync capture follows it
      if (tgl_drv == 1'b0) begin
         send(12'd3, 12'd3, 2'b00);
         repeat (5) @(negedge pclk);
      end
      send(12'd77, 12'd77, 2'b01);
      repeat (4) @(negedge pclk);
      rst = 1'b1;
      @(negedge pclk);
      rst = 1'b0;
      repeat (3) @(negedge pclk);
      vblnk_drv = 1'b1;
      @(negedge pclk);
      check("t6_rst_x1", 32'(if1.xpos_out), 0);
      check("t6_rst_upd1", 32'(if1.upd_pulse), 0);
      check("t6_rst_x0", 32'(if0.xpos_out), 0);
      vblnk_drv = 1'b0;

      // random phase: samples, vblank frames, occasional reset
      vcnt = 5; hold = 0;
      for (int c = 0; c < 3000; c++) begin
         @(negedge pclk);
         rst = ($urandom_range(0, 499) == 0);
         if (vcnt == 0) begin
            vblnk_drv = ~vblnk_drv;
            vcnt = $urandom_range(3, 30);
         end else begin
            vcnt--;
         end
         if (hold > 0) begin
            hold--;
         end else if ($urandom_range(0, 3) == 0) begin
            case ($urandom_range(0, 4))
               0: x_drv = 12'd799;
               1: x_drv = 12'd800;
               2: x_drv = 12'd0;
               3: x_drv = 12'd4095;
               default: x_drv = 12'($urandom_range(0, 4095));
            endcase
            y_drv = 12'($urandom_range(0, 4095));
            b_drv = 2'($urandom_range(0, 3));
            tgl_drv = ~tgl_drv;
            hold = S + 2 + $urandom_range(0, 6);
         end
      end
      repeat (3) @(negedge pclk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
